// File: rtl/sram_mp_ctrl.sv
// sram_mp_ctrl: NCH requesters share one byte-enabled DEPTH x DATA_W array through a
// round-robin arbiter; reads return through a channel-tagged RD_LAT-stage pipeline.
module sram_mp_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned NCH    = 4,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NCH-1:0]              req,
    input  logic [NCH-1:0]              we,
    input  logic [NCH*ADDR_W-1:0]       addr,
    input  logic [NCH*DATA_W-1:0]       wdata,
    input  logic [NCH*(DATA_W/8)-1:0]   be,
    output logic [NCH-1:0]              gnt,
    output logic [DATA_W-1:0]           rdata,
    output logic [NCH-1:0]              rvalid
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [NCH-1:0]    r_oh  [RD_LAT];
    logic [DATA_W-1:0] r_dat [RD_LAT];

    logic [NCH-1:0]    w_gnt;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;

    // Round-robin search from r_ptr; the winner's request fields drive the array port.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_acc     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_be      = '0;
        if (rstn) begin
            for (int unsigned off = 0; off < NCH; off++) begin
                idx = (32'(r_ptr) + off) % NCH;
                if (!w_acc && req[idx]) begin
                    w_acc      = 1'b1;
                    w_gnt[idx] = 1'b1;
                    w_ptr_nxt  = PTR_W'((idx + 1) % NCH);
                    w_we       = we[idx];
                    w_addr     = addr[idx*ADDR_W +: ADDR_W];
                    w_wdata    = wdata[idx*DATA_W +: DATA_W];
                    w_be       = be[idx*BE_W +: BE_W];
                end
            end
        end
    end

    assign gnt = w_gnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Array contents survive reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (w_acc && w_we) begin
            for (int unsigned j = 0; j < BE_W; j++) begin
                if (w_be[j]) begin
                    r_mem[w_addr][8*j +: 8] <= w_wdata[8*j +: 8];
                end
            end
        end
    end

    // Tag travels as a one-hot channel vector; data stages only load when a read moves in,
    // so the last stage holds the previously returned word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_oh[i]  <= '0;
                r_dat[i] <= '0;
            end
        end else begin
            r_oh[0] <= (w_acc && !w_we) ? w_gnt : '0;
            if (w_acc && !w_we) begin
                r_dat[0] <= r_mem[w_addr];
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_oh[i] <= r_oh[i-1];
                if (|r_oh[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign rvalid = r_oh[RD_LAT-1];
    assign rdata  = r_dat[RD_LAT-1];

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// tb_sram_mp_ctrl: vector table, hand sequences and random traffic on RD_LAT = 2, 1, 4
// instances sharing one stimulus, all checked against a queue-based reference model.
module tb_sram_mp_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int NCH    = 4;
    localparam int BE_W   = DATA_W / 8;
    localparam int NI     = 3;

    typedef struct {
        int                inst;
        int                due;
        int                ch;
        logic [DATA_W-1:0] data;
    } ret_t;

    typedef struct {
        int                ch;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   b;
        logic [DATA_W-1:0] exp;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*ADDR_W-1:0] addr;
    logic [NCH*DATA_W-1:0] wdata;
    logic [NCH*BE_W-1:0]   be;
    logic [NCH-1:0]        gnt_a [NI];
    logic [DATA_W-1:0]     rd_a  [NI];
    logic [NCH-1:0]        rv_a  [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_ptr  = 0;
    int lat_a   [NI];
    int rv_seen [NI];
    int rv_cnt  [NI];
    int acc_cnt [NCH];
    int acc_ch   = -1;
    int watch_ch = -1;
    logic [DATA_W-1:0] rv_dat [NI];
    logic [DATA_W-1:0] m_last [NI];
    logic [DATA_W-1:0] m_mem  [2**ADDR_W];
    ret_t exp_q [$];

    always #5 clk = ~clk;

    sram_mp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .RD_LAT(2)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt_a[0]), .rdata(rd_a[0]), .rvalid(rv_a[0]));
    sram_mp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt_a[1]), .rdata(rd_a[1]), .rvalid(rv_a[1]));
    sram_mp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .RD_LAT(4)) u_dut_l4 (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt_a[2]), .rdata(rd_a[2]), .rvalid(rv_a[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected grant: first requester at or after the pointer, modulo NCH.
    function automatic logic [NCH-1:0] model_gnt();
        logic [NCH-1:0] g;
        int i;
        g = '0;
        if (rstn) begin
            for (int o = 0; o < NCH; o++) begin
                i = (m_ptr + o) % NCH;
                if (g == '0 && req[i]) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic set_ch(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
        we[ch] = w;
        addr[ch*ADDR_W +: ADDR_W]  = a;
        wdata[ch*DATA_W +: DATA_W] = d;
        be[ch*BE_W +: BE_W]        = b;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        for (int d = 0; d < NI; d++) m_last[d] = '0;
    endtask

    // One clock: check grant before the edge, apply the accept to the model, check outputs after.
    task automatic step();
        logic [NCH-1:0] eg;
        logic [NCH-1:0] erv;
        logic [ADDR_W-1:0] a;
        ret_t r;
        int k;
        int fi;
        @(negedge clk);
        eg = model_gnt();
        for (int d = 0; d < NI; d++)
            chk($sformatf("gnt_lat%0d", lat_a[d]), 32'(gnt_a[d]), 32'(eg));
        @(posedge clk);
        cyc++;
        acc_ch = -1;
        k = -1;
        for (int i = 0; i < NCH; i++) if (eg[i]) k = i;
        if (k >= 0) begin
            acc_ch = k;
            acc_cnt[k]++;
            a = addr[k*ADDR_W +: ADDR_W];
            if (we[k]) begin
                for (int j = 0; j < BE_W; j++)
                    if (be[k*BE_W + j]) m_mem[a][8*j +: 8] = wdata[k*DATA_W + 8*j +: 8];
            end else begin
                for (int d = 0; d < NI; d++) begin
                    r.inst = d;
                    r.due  = cyc + lat_a[d] - 1;
                    r.ch   = k;
                    r.data = m_mem[a];
                    exp_q.push_back(r);
                end
            end
            m_ptr = (k + 1) % NCH;
        end
        #1;
        for (int d = 0; d < NI; d++) begin
            erv = '0;
            fi  = -1;
            foreach (exp_q[q]) if (exp_q[q].inst == d && exp_q[q].due == cyc) fi = q;
            if (fi >= 0) begin
                erv[exp_q[fi].ch] = 1'b1;
                m_last[d] = exp_q[fi].data;
                exp_q.delete(fi);
            end
            chk($sformatf("rvalid_lat%0d", lat_a[d]), 32'(rv_a[d]), 32'(erv));
            chk($sformatf("rdata_lat%0d", lat_a[d]), rd_a[d], m_last[d]);
            if (rv_a[d] != '0) rv_cnt[d]++;
            if (watch_ch >= 0 && rv_seen[d] < 0 && rv_a[d][watch_ch]) begin
                rv_seen[d] = cyc;
                rv_dat[d]  = rd_a[d];
            end
        end
    endtask

    task automatic issue(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b, output int t_acc);
        int n;
        set_ch(ch, w, a, d, b);
        req[ch] = 1'b1;
        n = 0;
        t_acc = -1;
        while (t_acc < 0 && n < 20) begin
            step();
            n++;
            if (acc_ch == ch) t_acc = cyc;
        end
        chk($sformatf("accept_ch%0d", ch), 32'(t_acc >= 0), 32'd1);
        req[ch] = 1'b0;
    endtask

    task automatic watch(input int ch);
        watch_ch = ch;
        for (int d = 0; d < NI; d++) rv_seen[d] = -1;
    endtask

    function automatic vec_t mk(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b,
                                input logic [DATA_W-1:0] exp);
        vec_t v;
        v.ch = ch; v.w = w; v.a = a; v.d = d; v.b = b; v.exp = exp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [$];
        vec_t v;
        int seq [$];
        int t0;
        int e;
        int n_exp;

        lat_a[0] = 2; lat_a[1] = 1; lat_a[2] = 4;
        for (int d = 0; d < NI; d++) begin
            m_last[d] = '0; rv_seen[d] = -1; rv_cnt[d] = 0; rv_dat[d] = '0;
        end
        for (int i = 0; i < NCH; i++) acc_cnt[i] = 0;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;

        // Reset with every channel requesting a write to its own index.
        #1 do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, ADDR_W'(i), 32'hA0A0_0000 + 32'(i), '1);
        req = '1;
        repeat (5) step();
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("reset_gnt_lat%0d", lat_a[d]), 32'(gnt_a[d]), 32'd0);
            chk($sformatf("reset_rvalid_lat%0d", lat_a[d]), 32'(rv_a[d]), 32'd0);
            chk($sformatf("reset_rdata_lat%0d", lat_a[d]), rd_a[d], 32'd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            seq.push_back(acc_ch);
        end
        req = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(seq[i]), 32'(i % NCH));

        // RAW with byte enables, be=0 write, partial-lane write.
        tbl.push_back(mk(1, 1'b1, 10'h3FF, 32'h1122_3344, 4'hF, 32'h0));
        tbl.push_back(mk(1, 1'b1, 10'h3FF, 32'hAABB_CCDD, 4'b0101, 32'h0));
        tbl.push_back(mk(1, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'h11BB_33DD));
        tbl.push_back(mk(2, 1'b1, 10'h000, 32'h1234_5678, 4'hF, 32'h0));
        tbl.push_back(mk(2, 1'b1, 10'h000, 32'hDEAD_BEEF, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1'b0, 10'h000, 32'h0, 4'h0, 32'h1234_5678));
        tbl.push_back(mk(3, 1'b1, 10'h001, 32'hCAFE_F00D, 4'hF, 32'h0));
        tbl.push_back(mk(3, 1'b1, 10'h001, 32'h0000_0000, 4'b0110, 32'h0));
        tbl.push_back(mk(3, 1'b0, 10'h001, 32'h0, 4'h0, 32'hCA00_000D));
        foreach (tbl[r]) begin
            v = tbl[r];
            if (!v.w) watch(v.ch);
            issue(v.ch, v.w, v.a, v.d, v.b, t0);
            if (!v.w) begin
                repeat (5) step();
                for (int d = 0; d < NI; d++) begin
                    chk($sformatf("vec%0d_offset_lat%0d", r, lat_a[d]), 32'(rv_seen[d] - t0 + 1), 32'(lat_a[d]));
                    chk($sformatf("vec%0d_data_lat%0d", r, lat_a[d]), rv_dat[d], v.exp);
                end
                watch_ch = -1;
            end
        end

        // Write on one edge, read of the same word on the very next edge.
        set_ch(0, 1'b1, 10'd5, 32'h5555_AAAA, 4'hF);
        set_ch(1, 1'b0, 10'd5, 32'h0, 4'h0);
        watch(1);
        req = 4'b0011;
        step();
        chk("raw_first_ch0", 32'(acc_ch), 32'd0);
        req[0] = 1'b0;
        step();
        chk("raw_second_ch1", 32'(acc_ch), 32'd1);
        t0 = cyc;
        req = '0;
        repeat (5) step();
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("raw_offset_lat%0d", lat_a[d]), 32'(rv_seen[d] - t0 + 1), 32'(lat_a[d]));
            chk($sformatf("raw_data_lat%0d", lat_a[d]), rv_dat[d], 32'h5555_AAAA);
        end
        watch_ch = -1;

        // Fairness: all channels read their own index continuously.
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 1'b0, ADDR_W'(i), 32'h0, 4'h0);
            acc_cnt[i] = 0;
        end
        e = m_ptr;
        req = '1;
        for (int c = 0; c < 40; c++) begin
            step();
            chk($sformatf("fair_rot%0d", c), 32'(acc_ch), 32'(e));
            e = (e + 1) % NCH;
        end
        req = '0;
        repeat (6) step();
        for (int i = 0; i < NCH; i++) chk($sformatf("fair_share_ch%0d", i), 32'(acc_cnt[i]), 32'd10);

        // Reset right after two back-to-back read accepts.
        for (int d = 0; d < NI; d++) rv_cnt[d] = 0;
        set_ch(0, 1'b0, 10'd2, 32'h0, 4'h0);
        set_ch(1, 1'b0, 10'd3, 32'h0, 4'h0);
        req = 4'b0011;
        step();
        req[acc_ch >= 0 ? acc_ch : 0] = 1'b0;
        step();
        req = '0;
        do_reset();
        repeat (3) step();
        rstn = 1'b1;
        repeat (6) step();
        for (int d = 0; d < NI; d++) begin
            n_exp = 0;
            for (int j = 0; j < 2; j++) if (j + lat_a[d] <= 2) n_exp++;
            chk($sformatf("reset_discard_lat%0d", lat_a[d]), 32'(rv_cnt[d]), 32'(n_exp));
        end
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 10'd2, 32'h0, 4'h0);
        watch(0);
        req = '1;
        step();
        chk("reset_ptr_first_ch0", 32'(acc_ch), 32'd0);
        req = '0;
        repeat (6) step();
        for (int d = 0; d < NI; d++)
            chk($sformatf("retained_data_lat%0d", lat_a[d]), rv_dat[d], 32'hA0A0_0002);
        watch_ch = -1;

        // Random traffic over a fully written window of 16 words.
        for (int a = 4; a < 16; a++) issue(0, 1'b1, ADDR_W'(a), $urandom, 4'hF, t0);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!req[i] && $urandom_range(0, 3) != 0) begin
                    set_ch(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom, BE_W'($urandom));
                    req[i] = 1'b1;
                end
            end
            step();
            if (acc_ch >= 0) req[acc_ch] = 1'b0;
        end
        req = '0;
        repeat (6) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
